// File: rtl/dmem_handshake.sv
// dmem_handshake
// Single-port data memory behind the core's memory stage. It accepts one
// load/store at a time over a valid/yumi request handshake, answers after a
// fixed latency and holds the response until the core consumes it.
//
// Parameters:
//   addr_width_p : word-address bits (storage = 2^addr_width_p x 32 bits)
//   latency_p    : cycles from the acceptance edge to the first resp_valid_o
//                  cycle (1..15)
//
// Ports:
//   clk          : clock
//   reset        : synchronous, active-low reset
//   req_valid_i  : request present
//   req_wen_i    : 1 = store, 0 = load
//   req_byte_i   : 1 = byte access, 0 = word access
//   req_addr_i   : byte address (wraps modulo memory size)
//   req_wdata_i  : store data (byte stores use [7:0])
//   req_yumi_o   : request accepted this cycle (combinational)
//   resp_valid_o : response available
//   resp_data_o  : load data, 0 for stores
//   resp_yumi_i  : core consumes the response
//   err_o        : sticky misaligned-word-access flag (only with
//                  DMEM_ALIGN_CHECK_EN defined)
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready; a valid request is accepted combinationally
// BUSY  | latency countdown after acceptance
// RESP  | response held on resp_data_o until resp_yumi_i

module dmem_handshake #(
   parameter int addr_width_p = 10,
   parameter int latency_p    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid_i,
   input  logic        req_wen_i,
   input  logic        req_byte_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        req_yumi_o,
   output logic        resp_valid_o,
   output logic [31:0] resp_data_o,
   input  logic        resp_yumi_i
`ifdef DMEM_ALIGN_CHECK_EN
  ,output logic        err_o
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   // With a one-cycle latency the read happens on the acceptance edge
   // itself, so the read path must use the live request instead of the
   // captured copy.
   localparam bit direct_c = (latency_p == 1);

   state_t                  state;
   logic [3:0]              cnt;
   logic                    wen_q;
   logic                    byte_q;
   logic [addr_width_p-1:0] idx_q;
   logic [1:0]              lane_q;
   logic                    misal_q;

   logic [31:0]             mem [2**addr_width_p];

   logic [addr_width_p-1:0] req_idx;
   logic [1:0]              req_lane;
   logic                    misal;
   logic                    unused_addr;

   logic [addr_width_p-1:0] rd_idx;
   logic [1:0]              rd_lane;
   logic                    rd_byte;
   logic                    rd_wen;
   logic                    rd_misal;
   logic [31:0]             rd_word;
   logic [31:0]             resp_next;

   assign req_idx     = req_addr_i[addr_width_p+1:2];
   assign req_lane    = req_addr_i[1:0];
   assign unused_addr = ^req_addr_i[31:addr_width_p+2];

`ifdef DMEM_ALIGN_CHECK_EN
   assign misal = ~req_byte_i & (req_lane != 2'd0);
`else
   assign misal = 1'b0;
`endif

   assign req_yumi_o = (state == IDLE) & req_valid_i;

   assign rd_idx   = direct_c ? req_idx    : idx_q;
   assign rd_lane  = direct_c ? req_lane   : lane_q;
   assign rd_byte  = direct_c ? req_byte_i : byte_q;
   assign rd_wen   = direct_c ? req_wen_i  : wen_q;
   assign rd_misal = direct_c ? misal      : misal_q;
   assign rd_word  = mem[rd_idx];

   always_comb begin
      resp_next = 32'd0;
      if (!rd_wen && !rd_misal) begin
         if (rd_byte) resp_next = {24'd0, rd_word[{rd_lane, 3'b000} +: 8]};
         else         resp_next = rd_word;
      end
   end

   // Stores commit on the acceptance edge; misaligned word stores are
   // dropped when the alignment check is built in.
   always_ff @(posedge clk) begin
      if (reset && req_yumi_o && req_wen_i && !misal) begin
         if (req_byte_i) mem[req_idx][{req_lane, 3'b000} +: 8] <= req_wdata_i[7:0];
         else            mem[req_idx] <= req_wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         resp_valid_o <= 1'b0;
         resp_data_o  <= 32'd0;
         wen_q        <= 1'b0;
         byte_q       <= 1'b0;
         idx_q        <= '0;
         lane_q       <= 2'd0;
         misal_q      <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
         err_o        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  wen_q   <= req_wen_i;
                  byte_q  <= req_byte_i;
                  idx_q   <= req_idx;
                  lane_q  <= req_lane;
                  misal_q <= misal;
`ifdef DMEM_ALIGN_CHECK_EN
                  if (misal) err_o <= 1'b1;
`endif
                  if (direct_c) begin
                     state        <= RESP;
                     resp_valid_o <= 1'b1;
                     resp_data_o  <= resp_next;
                  end else begin
                     state <= BUSY;
                     cnt   <= 4'(latency_p - 1);
                  end
               end
            end
            BUSY: begin
               // The last BUSY cycle is the one where the counter would
               // reach zero; that edge moves straight into RESP.
               if (cnt <= 4'd1) begin
                  cnt          <= 4'd0;
                  state        <= RESP;
                  resp_valid_o <= 1'b1;
                  resp_data_o  <= resp_next;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_yumi_i) begin
                  state        <= IDLE;
                  resp_valid_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_handshake.sv
module tb_dmem_handshake;

   logic        clk;
   logic        reset;
   logic        req_valid_i;
   logic        req_wen_i;
   logic        req_byte_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        req_yumi_o;
   logic        resp_valid_o;
   logic [31:0] resp_data_o;
   logic        resp_yumi_i;
`ifdef DMEM_ALIGN_CHECK_EN
   logic        err_o;
`endif

   int assert_cnt = 0;
   int fail_cnt   = 0;

   dmem_handshake #(.addr_width_p(10), .latency_p(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid_i  (req_valid_i),
      .req_wen_i    (req_wen_i),
      .req_byte_i   (req_byte_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .req_yumi_o   (req_yumi_o),
      .resp_valid_o (resp_valid_o),
      .resp_data_o  (resp_data_o),
      .resp_yumi_i  (resp_yumi_i)
`ifdef DMEM_ALIGN_CHECK_EN
     ,.err_o        (err_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus only: issues one request, waits (bounded) for the response,
   // consumes it. lat = 0 means no response within the budget.
   task automatic access(input logic wen, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit keep_yumi,
                         output logic yumi_seen, output int lat, output logic [31:0] data);
      @(negedge clk);
      req_valid_i = 1'b1;
      req_wen_i   = wen;
      req_byte_i  = byt;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      #1 yumi_seen = req_yumi_o;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (resp_valid_o) begin
            lat = n;
            break;
         end
      end
      data = resp_data_o;
      resp_yumi_i = 1'b1;
      @(posedge clk);
      #1;
      if (!keep_yumi) resp_yumi_i = 1'b0;
   endtask

   task automatic test_reset;
      reset       = 1'b0;
      req_valid_i = 1'b0;
      req_wen_i   = 1'b0;
      req_byte_i  = 1'b0;
      req_addr_i  = 32'd0;
      req_wdata_i = 32'd0;
      resp_yumi_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      assert_cnt++;
      if (req_yumi_o !== 1'b0) begin
         fail_cnt++; $display("FAIL reset_req_yumi: got %b want 0", req_yumi_o);
      end
      assert_cnt++;
      if (resp_valid_o !== 1'b0) begin
         fail_cnt++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid_o);
      end
      assert_cnt++;
      if (resp_data_o !== 32'd0) begin
         fail_cnt++; $display("FAIL reset_resp_data: got %h want 0", resp_data_o);
      end
`ifdef DMEM_ALIGN_CHECK_EN
      assert_cnt++;
      if (err_o !== 1'b0) begin
         fail_cnt++; $display("FAIL reset_err: got %b want 0", err_o);
      end
`endif
   endtask

   task automatic test_word_yumi_high;
      logic y; int lat; logic [31:0] d;
      resp_yumi_i = 1'b1;
      access(1'b1, 1'b0, 32'h10, 32'hCAFEF00D, 1'b1, y, lat, d);
      assert_cnt++;
      if (y !== 1'b1) begin fail_cnt++; $display("FAIL store_req_yumi: got %b want 1", y); end
      assert_cnt++;
      if (lat !== 2) begin fail_cnt++; $display("FAIL store_latency: got %0d want 2", lat); end
      assert_cnt++;
      if (d !== 32'd0) begin fail_cnt++; $display("FAIL store_resp_data: got %h want 0", d); end
      assert_cnt++;
      if (resp_valid_o !== 1'b0) begin
         fail_cnt++; $display("FAIL store_resp_one_cycle: got %b want 0", resp_valid_o);
      end
      access(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, y, lat, d);
      assert_cnt++;
      if (y !== 1'b1) begin fail_cnt++; $display("FAIL load_req_yumi: got %b want 1", y); end
      assert_cnt++;
      if (lat !== 2) begin fail_cnt++; $display("FAIL load_latency: got %0d want 2", lat); end
      assert_cnt++;
      if (d !== 32'hCAFEF00D) begin fail_cnt++; $display("FAIL load_word: got %h want cafef00d", d); end
      assert_cnt++;
      if (resp_valid_o !== 1'b0) begin
         fail_cnt++; $display("FAIL load_resp_one_cycle: got %b want 0", resp_valid_o);
      end
      resp_yumi_i = 1'b0;
   endtask

   task automatic test_byte;
      logic y; int lat; logic [31:0] d;
      access(1'b1, 1'b0, 32'h20, 32'h11223344, 1'b0, y, lat, d);
      access(1'b1, 1'b1, 32'h22, 32'hFFFFFFAA, 1'b0, y, lat, d);
      assert_cnt++;
      if (d !== 32'd0) begin fail_cnt++; $display("FAIL byte_store_data: got %h want 0", d); end
      access(1'b0, 1'b1, 32'h22, 32'h0, 1'b0, y, lat, d);
      assert_cnt++;
      if (d !== 32'h000000AA) begin fail_cnt++; $display("FAIL byte_load: got %h want 000000aa", d); end
      access(1'b0, 1'b1, 32'h23, 32'h0, 1'b0, y, lat, d);
      assert_cnt++;
      if (d !== 32'h00000011) begin fail_cnt++; $display("FAIL byte_load_lane3: got %h want 00000011", d); end
      access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, y, lat, d);
      assert_cnt++;
      if (d !== 32'h11AA3344) begin fail_cnt++; $display("FAIL word_after_byte: got %h want 11aa3344", d); end
   endtask

   task automatic test_hold;
      int lat; int bad;
      @(negedge clk);
      req_valid_i = 1'b1;
      req_wen_i   = 1'b0;
      req_byte_i  = 1'b0;
      req_addr_i  = 32'h10;
      @(posedge clk);
      #1 req_addr_i = 32'h20;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (resp_valid_o) begin lat = n; break; end
      end
      assert_cnt++;
      if (lat !== 2) begin fail_cnt++; $display("FAIL hold_latency: got %0d want 2", lat); end
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         if (resp_valid_o !== 1'b1 || resp_data_o !== 32'hCAFEF00D || req_yumi_o !== 1'b0) bad++;
      end
      assert_cnt++;
      if (bad !== 0) begin
         fail_cnt++; $display("FAIL hold_stable: %0d bad cycles want 0 (valid %b data %h yumi %b)",
                               bad, resp_valid_o, resp_data_o, req_yumi_o);
      end
      resp_yumi_i = 1'b1;
      #1;
      assert_cnt++;
      if (req_yumi_o !== 1'b0) begin
         fail_cnt++; $display("FAIL hold_no_accept_on_consume: got %b want 0", req_yumi_o);
      end
      @(posedge clk);
      #1 resp_yumi_i = 1'b0;
      @(negedge clk);
      assert_cnt++;
      if (req_yumi_o !== 1'b1 || resp_valid_o !== 1'b0) begin
         fail_cnt++; $display("FAIL hold_next_accept: yumi %b valid %b want 1 0", req_yumi_o, resp_valid_o);
      end
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (resp_valid_o) begin lat = n; break; end
      end
      assert_cnt++;
      if (lat !== 2 || resp_data_o !== 32'h11AA3344) begin
         fail_cnt++; $display("FAIL hold_followup_load: lat %0d data %h want 2 11aa3344", lat, resp_data_o);
      end
      resp_yumi_i = 1'b1;
      @(posedge clk);
      #1 resp_yumi_i = 1'b0;
   endtask

   task automatic test_wrap;
      logic y; int lat; logic [31:0] d;
      access(1'b1, 1'b0, 32'h0,    32'hA5A50001, 1'b0, y, lat, d);
      access(1'b1, 1'b0, 32'h1000, 32'h5A5A0002, 1'b0, y, lat, d);
      access(1'b0, 1'b0, 32'h0,    32'h0,        1'b0, y, lat, d);
      assert_cnt++;
      if (d !== 32'h5A5A0002) begin fail_cnt++; $display("FAIL wrap: got %h want 5a5a0002", d); end
   endtask

   task automatic test_reset_mid;
      logic y; int lat; logic [31:0] d; int seen;
      // store interrupted by reset while BUSY
      @(negedge clk);
      req_valid_i = 1'b1; req_wen_i = 1'b1; req_byte_i = 1'b0;
      req_addr_i = 32'h30; req_wdata_i = 32'h0BADBEEF;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      // load interrupted by reset while BUSY
      @(negedge clk);
      req_valid_i = 1'b1; req_wen_i = 1'b0; req_addr_i = 32'h30;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid_o !== 1'b0) seen++;
      end
      assert_cnt++;
      if (seen !== 0) begin fail_cnt++; $display("FAIL reset_mid_no_resp: got %0d valid cycles want 0", seen); end
      access(1'b0, 1'b0, 32'h30, 32'h0, 1'b0, y, lat, d);
      assert_cnt++;
      if (y !== 1'b1) begin fail_cnt++; $display("FAIL reset_mid_idle: got %b want 1", y); end
      assert_cnt++;
      if (d !== 32'h0BADBEEF) begin fail_cnt++; $display("FAIL reset_mid_store_kept: got %h want 0badbeef", d); end
   endtask

`ifdef DMEM_ALIGN_CHECK_EN
   task automatic test_align;
      logic y; int lat; logic [31:0] d;
      access(1'b1, 1'b0, 32'h21, 32'hFFFFFFFF, 1'b0, y, lat, d);
      assert_cnt++;
      if (lat !== 2) begin fail_cnt++; $display("FAIL align_latency: got %0d want 2", lat); end
      assert_cnt++;
      if (err_o !== 1'b1) begin fail_cnt++; $display("FAIL align_err: got %b want 1", err_o); end
      access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, y, lat, d);
      assert_cnt++;
      if (d !== 32'h11AA3344) begin fail_cnt++; $display("FAIL align_store_dropped: got %h want 11aa3344", d); end
      access(1'b0, 1'b0, 32'h22, 32'h0, 1'b0, y, lat, d);
      assert_cnt++;
      if (d !== 32'd0) begin fail_cnt++; $display("FAIL align_load_zero: got %h want 0", d); end
      assert_cnt++;
      if (err_o !== 1'b1) begin fail_cnt++; $display("FAIL align_err_sticky: got %b want 1", err_o); end
   endtask
`endif

   initial begin
      test_reset;
      test_word_yumi_high;
      test_byte;
      test_hold;
      test_wrap;
`ifdef DMEM_ALIGN_CHECK_EN
      test_align;
`endif
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, timeout reached");
      $fatal(1, "watchdog");
   end

endmodule
